// File: rtl/spike_delay_synapse.sv
// Delayed, weighted fan-in synapse: spikes are scaled by signed weights, parked in a
// circular buffer of per-timestep accumulators, and read out as a saturated current.
module spike_delay_synapse #(
    parameter int unsigned N_INPUTS    = 4,
    parameter int unsigned DELAY_SLOTS = 8,
    parameter int unsigned DW          = $clog2(DELAY_SLOTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [N_INPUTS-1:0]       spike_in,
    input  logic [8*N_INPUTS-1:0]     weights,
    input  logic [DW*N_INPUTS-1:0]    delays,
    output logic signed [7:0]         current_out,
    output logic                      current_valid,
    output logic                      pending
);

    localparam int unsigned SW = 12;
    localparam int unsigned AW = 14;
    localparam logic signed [AW-1:0] S12_MAX = AW'(2047);
    localparam logic signed [AW-1:0] S12_MIN = AW'(-2048);
    localparam logic signed [AW-1:0] S8_MAX  = AW'(127);
    localparam logic signed [AW-1:0] S8_MIN  = AW'(-128);

    logic signed [SW-1:0] slot     [DELAY_SLOTS];
    logic signed [SW-1:0] slot_nxt [DELAY_SLOTS];
    logic signed [AW-1:0] dsum     [DELAY_SLOTS];
    logic [DW-1:0]        ptr;
    logic signed [AW-1:0] out_sum;

    function automatic logic signed [SW-1:0] sat12(input logic signed [AW-1:0] v);
        if (v > S12_MAX)      return SW'(S12_MAX);
        else if (v < S12_MIN) return SW'(S12_MIN);
        else                  return SW'(v);
    endfunction

    function automatic logic signed [7:0] sat8(input logic signed [AW-1:0] v);
        if (v > S8_MAX)      return 8'(S8_MAX);
        else if (v < S8_MIN) return 8'(S8_MIN);
        else                 return 8'(v);
    endfunction

    // Sum of weights of this step's spikes, grouped by requested delay
    always_comb begin
        for (int d = 0; d < DELAY_SLOTS; d++) dsum[d] = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (spike_in[i])
                dsum[delays[DW*i +: DW]] = dsum[delays[DW*i +: DW]]
                                         + AW'($signed(weights[8*i +: 8]));
        end
    end

    // Slot at offset 0 from ptr is consumed this step; the others accumulate
    for (genvar k = 0; k < DELAY_SLOTS; k++) begin : g_slot
        logic [DW-1:0]        off;
        logic signed [AW-1:0] acc;
        assign off         = DW'(k) - ptr;
        assign acc         = AW'(slot[k]) + dsum[off];
        assign slot_nxt[k] = (off == '0) ? '0 : sat12(acc);
    end

    assign out_sum = AW'(slot[ptr]) + dsum[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DELAY_SLOTS; k++) slot[k] <= '0;
            ptr           <= '0;
            current_out   <= '0;
            current_valid <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < DELAY_SLOTS; k++) slot[k] <= '0;
            ptr           <= '0;
            current_out   <= '0;
            current_valid <= 1'b0;
        end else if (enable) begin
            for (int k = 0; k < DELAY_SLOTS; k++) slot[k] <= slot_nxt[k];
            ptr           <= ptr + DW'(1);
            current_out   <= sat8(out_sum);
            current_valid <= 1'b1;
        end else begin
            current_valid <= 1'b0;
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < DELAY_SLOTS; k++)
            if (slot[k] != '0) pending = 1'b1;
    end

endmodule

// File: tb/tb_spike_delay_synapse.sv
// Directed bench for spike_delay_synapse (4 inputs, 8 slots): vector table plus
// hand-written multi-cycle sequences for wrap, idle, clear, slot saturation and reset.
module tb_spike_delay_synapse;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               clear = 1'b0;
    logic [3:0]         spike_in = '0;
    logic [31:0]        weights = '0;
    logic [11:0]        delays = '0;
    logic signed [7:0]  current_out;
    logic               current_valid;
    logic               pending;

    int checks = 0;
    int errors = 0;

    spike_delay_synapse #(.N_INPUTS(4), .DELAY_SLOTS(8), .DW(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .clear         (clear),
        .spike_in      (spike_in),
        .weights       (weights),
        .delays        (delays),
        .current_out   (current_out),
        .current_valid (current_valid),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              en;
        logic              clr;
        logic [3:0]        sp;
        logic [31:0]       w;
        logic [11:0]       d;
        logic signed [7:0] eo;
        logic              ev;
        logic              ep;
    } vec_t;

    function automatic logic [31:0] pw(input int w0, input int w1, input int w2, input int w3);
        return {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    endfunction

    function automatic logic [11:0] pd(input int d0, input int d1, input int d2, input int d3);
        return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    function automatic vec_t mk(input logic en, input logic clr, input logic [3:0] sp,
                                input logic [31:0] w, input logic [11:0] d,
                                input int eo, input logic ev, input logic ep);
        vec_t v;
        v.en = en; v.clr = clr; v.sp = sp; v.w = w; v.d = d;
        v.eo = 8'(eo); v.ev = ev; v.ep = ep;
        return v;
    endfunction

    task automatic check(input string name, input int eo, input logic ev, input logic ep);
        checks++;
        if (current_out !== 8'(eo)) begin
            errors++;
            $display("FAIL %s current_out got %0d expected %0d", name, current_out, eo);
        end
        checks++;
        if (current_valid !== ev) begin
            errors++;
            $display("FAIL %s current_valid got %b expected %b", name, current_valid, ev);
        end
        checks++;
        if (pending !== ep) begin
            errors++;
            $display("FAIL %s pending got %b expected %b", name, pending, ep);
        end
    endtask

    // Drive one cycle of inputs and sample just after the rising edge
    task automatic step(input logic en, input logic clr, input logic [3:0] sp,
                        input logic [31:0] w, input logic [11:0] d);
        enable = en; clear = clr; spike_in = sp; weights = w; delays = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_en();
        step(1'b1, 1'b0, 4'b0000, '0, '0);
    endtask

    task automatic do_reset();
        enable = 1'b0; clear = 1'b0; spike_in = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs [17];

    initial begin
        vecs[0]  = mk(1, 0, 4'b0001, pw(20, 0, 0, 0),        pd(3, 0, 0, 0), 0,    1, 1);
        vecs[1]  = mk(1, 0, 4'b0000, '0,                     '0,             0,    1, 1);
        vecs[2]  = mk(1, 0, 4'b0000, '0,                     '0,             0,    1, 1);
        vecs[3]  = mk(1, 0, 4'b0000, '0,                     '0,             20,   1, 0);
        vecs[4]  = mk(1, 0, 4'b0000, '0,                     '0,             0,    1, 0);
        vecs[5]  = mk(1, 0, 4'b1111, pw(10, -3, 7, 1),       pd(0, 0, 0, 0), 15,   1, 0);
        vecs[6]  = mk(0, 0, 4'b1111, pw(10, -3, 7, 1),       pd(0, 0, 0, 0), 15,   0, 0);
        vecs[7]  = mk(1, 0, 4'b1111, pw(100, 100, 100, 100), pd(2, 2, 2, 2), 0,    1, 1);
        vecs[8]  = mk(1, 0, 4'b0000, '0,                     '0,             0,    1, 1);
        vecs[9]  = mk(1, 0, 4'b0000, '0,                     '0,             127,  1, 0);
        vecs[10] = mk(1, 0, 4'b1111, pw(-100, -100, -100, -100), pd(2, 2, 2, 2), 0, 1, 1);
        vecs[11] = mk(1, 0, 4'b0000, '0,                     '0,             0,    1, 1);
        vecs[12] = mk(1, 0, 4'b0000, '0,                     '0,             -128, 1, 0);
        vecs[13] = mk(1, 0, 4'b1111, pw(100, 100, -100, 50), pd(1, 1, 1, 1), 0,    1, 1);
        vecs[14] = mk(1, 0, 4'b0000, '0,                     '0,             127,  1, 0);
        vecs[15] = mk(1, 0, 4'b0011, pw(60, -10, 0, 0),      pd(1, 0, 0, 0), -10,  1, 1);
        vecs[16] = mk(1, 0, 4'b0001, pw(5, 0, 0, 0),         pd(0, 0, 0, 0), 65,   1, 0);

        #1;
        check("reset_state", 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].sp, vecs[i].w, vecs[i].d);
            check($sformatf("vec%0d", i), int'(vecs[i].eo), vecs[i].ev, vecs[i].ep);
        end

        // Delay 7 issued at ptr 6 lands 7 enables later, across the 7->0 wrap
        do_reset();
        for (int n = 0; n < 6; n++) idle_en();
        step(1'b1, 1'b0, 4'b0001, pw(5, 0, 0, 0), pd(7, 0, 0, 0));
        check("wrap_issue", 0, 1'b1, 1'b1);
        for (int n = 1; n <= 7; n++) begin
            idle_en();
            check($sformatf("wrap_n%0d", n), (n == 7) ? 5 : 0, 1'b1, (n == 7) ? 1'b0 : 1'b1);
        end

        // Seven steps all aimed at one slot: 3556 must clamp to 2047, not wrap negative
        do_reset();
        for (int t = 0; t < 7; t++) begin
            step(1'b1, 1'b0, 4'b1111, pw(127, 127, 127, 127), pd(7 - t, 7 - t, 7 - t, 7 - t));
            check($sformatf("stack_t%0d", t), 0, 1'b1, 1'b1);
        end
        idle_en();
        check("stack_out", 127, 1'b1, 1'b0);

        // Idle gap holds output and pending; delayed weight appears on 2nd enable
        do_reset();
        step(1'b1, 1'b0, 4'b0011, pw(33, 9, 0, 0), pd(2, 0, 0, 0));
        check("gap_issue", 9, 1'b1, 1'b1);
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 1'b0, 4'b1111, pw(1, 1, 1, 1), '0);
            check($sformatf("gap_idle%0d", n), 9, 1'b0, 1'b1);
        end
        idle_en();
        check("gap_en1", 0, 1'b1, 1'b1);
        idle_en();
        check("gap_en2", 33, 1'b1, 1'b0);

        // Clear wins over enable and flushes everything pending
        do_reset();
        step(1'b1, 1'b0, 4'b0011, pw(40, -7, 0, 0), pd(3, 5, 0, 0));
        check("clr_issue", 0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 4'b0001, pw(77, 0, 0, 0), pd(0, 0, 0, 0));
        check("clr_edge", 0, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            idle_en();
            check($sformatf("clr_after%0d", n), 0, 1'b1, 1'b0);
        end

        // Asynchronous reset between edges drops in-flight contributions
        do_reset();
        step(1'b1, 1'b0, 4'b0011, pw(50, 11, 0, 0), pd(2, 0, 0, 0));
        check("rst_issue", 11, 1'b1, 1'b1);
        @(negedge clk);
        enable = 1'b0; spike_in = '0;
        reset = 1'b1;
        #1;
        check("rst_async", 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            idle_en();
            check($sformatf("rst_after%0d", n), 0, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_delay_synapse.md
# spike_delay_synapse

Fan-in synapse stage that sits upstream of each leaky integrate-and-fire neuron and drives its `input_current` port. It receives binary spike events from `N_INPUTS` presynaptic neurons, weights each spike by a signed 8-bit synaptic weight, delays it by a per-input programmable number of timesteps through a circular accumulation buffer, and presents the summed, saturated current for the current timestep. Timesteps advance on the same `enable` strobe that gates the neuron update.

## Interface
- `N_INPUTS`, default 4: number of presynaptic spike lines (1..8).
- `DELAY_SLOTS`, default 8: number of buffer slots; must be a power of two (2..16). Legal delays are 0..`DELAY_SLOTS`-1.
- `DW`, default `$clog2(DELAY_SLOTS)`: delay field width per input.
- Clocking and reset (decided): one clock, `clk`; `reset` is asynchronous and active-high.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `enable` input 1: timestep strobe, same signal that drives the neuron `enable`.
- `clear` input 1: synchronous flush of all pending slots; has priority over `enable`.
- `spike_in` input `N_INPUTS`: presynaptic spikes; bit i is sampled only in `enable` cycles.
- `weights` input `8*N_INPUTS`: signed two's-complement weights; input i uses bits [8i+7:8i].
- `delays` input `DW*N_INPUTS`: unsigned delay of input i in timesteps, bits [DW*i+DW-1:DW*i].
- `current_out` output 8: signed saturated synaptic current; connects to neuron `input_current`.
- `current_valid` output 1: one-cycle pulse marking a `current_out` update.
- `pending` output 1: high when any buffer slot is nonzero.

## Operation
- State: `DELAY_SLOTS` accumulators `slot[k]`, each 12-bit signed; read pointer `ptr` (DW bits); registered outputs.
- On each `enable` cycle (with `clear` low), the following happen in one clock edge:
  - Delay-0 sum: S0 = sum of sign-extended `weights[i]` over all i with `spike_in[i]`=1 and `delays[i]`=0.
  - `current_out` <= sat8(`slot[ptr]` + S0), where sat8 clamps to [-128, +127]. Compute at 13 bits or wider, so there is no intermediate wrap.
  - `slot[ptr]` <= 0.
  - For each d in 1..`DELAY_SLOTS`-1, `slot[(ptr+d) mod DELAY_SLOTS]` <= sat12(old value + sum of weights of spiking inputs with delay d). sat12 clamps to [-2048, +2047].
  - `ptr` <= `ptr`+1, wrapping from `DELAY_SLOTS`-1 to 0.
  - `current_valid` <= 1.
- A spike on input i with delay d sampled at timestep t contributes to `current_out` at timestep t+d, i.e. on the d-th following `enable` edge. Delay 0 contributes in the same edge.
- Multiple inputs that target the same slot sum in the same cycle. Contributions are order-independent because they are summed before saturation.
- Delays and weights are sampled at spike time. Changing them later does not move contributions that are already buffered.
- On cycles where `enable` is 0 and `clear` is 0: slots, `ptr` and `current_out` hold; `current_valid` <= 0; `spike_in` is ignored.
- `clear`=1: all slots <= 0, `ptr` <= 0, `current_out` <= 0, `current_valid` <= 0. Any `enable` or spikes in the same cycle are discarded.
- `pending` is a combinational OR-reduce over all slots being nonzero, evaluated after the edge.

## Timing
- Reset values: all slots 0, `ptr` 0, `current_out` 0, `current_valid` 0, `pending` 0. Reset acts immediately and needs no clock.
- Latency: `current_out` is registered. It becomes valid one clock after the `enable` edge samples it and is held until the next `enable`.
- Back-to-back `enable` on every clock is supported at full rate.
- Reset asserted mid-run drops every in-flight contribution. The first `enable` after deassertion reads slot 0.
- Wrap-around: delay `DELAY_SLOTS`-1 issued at `ptr`=k targets slot (k-1) mod `DELAY_SLOTS`. This is legal because `slot[k]` is itself being cleared on that edge.

## Test plan
- Single spike, delay 3: reset; weight0=+20, delay0=3; spike_in=0001 on one enable, then enables with no spikes. Expected `current_out`: 0, 0, 0, +20, then 0. `current_valid` pulses after each enable.
- Delay 0 plus summation: weights {+10, -3, +7, +1}, all delays 0, spike_in=1111. Expected `current_out`=+15 on that edge.
- Saturation: four inputs each +100, all delays 2, spiking on 1 step. Two enables later, `current_out`=+127. Repeat with -100 each: `current_out`=-128. 12-bit slots must never wrap: spike all inputs at weight +127 for 7 consecutive steps with staggered delays, and the output must not go negative.
- Pointer wrap: delay 7 (`DELAY_SLOTS`=8), spike issued at `ptr`=6, weight +5. The +5 appears exactly 7 enables later. Check across the 7→0 wrap.
- Idle gaps and clear: spike with delay 2, then 5 cycles with `enable`=0. `current_out` holds and `pending`=1. The second following enable outputs the weight. A separate run asserts `clear` while contributions are pending: afterwards `pending`=0 and all later outputs are 0.
- Async reset mid-run: assert `reset` between clock edges while slots are nonzero. Outputs go to 0 immediately, `pending`=0, and no stale current appears after release.
